p2s_rr_sched: RTL and testbench

//   Round-robin scheduler that shares one parallel_to_serial shifter among NREQ

---
 rtl/p2s_rr_sched_if.sv | 35 +++
 rtl/p2s_rr_sched.sv | 156 +++++++++++++++
 tb/tb_p2s_rr_sched.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/p2s_rr_sched_if.sv
// Bundle for p2s_rr_sched: producer handshakes on one side, the serializer
// load/data strobe plus status on the other.
interface p2s_rr_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  ser_load;
  logic [WIDTH-1:0]      ser_data;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready,
    input  ser_load,
    input  ser_data,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready,
    output ser_load,
    output ser_data,
    output grant_id,
    output busy
  );
endinterface

// File: rtl/p2s_rr_sched.sv
// Round-robin scheduler sharing one parallel-to-serial shifter among NREQ producers.
// Define P2S_ARB_GAP_EN to insert a one-cycle GAP state (idle serial bit) between frames.
module p2s_rr_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input logic           clk,
  input logic           rst,
  p2s_rr_sched_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
`ifdef P2S_ARB_GAP_EN
  localparam logic [1:0] S_GAP   = 2'd3;
`endif

  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 2);

  logic [1:0]       state_q,     state_d;
  logic [CW-1:0]    bit_cnt_q,   bit_cnt_d;
  logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
  logic             ser_load_q,  ser_load_d;
  logic [WIDTH-1:0] ser_data_q,  ser_data_d;
  logic [IDW-1:0]   grant_id_q,  grant_id_d;
  logic [NREQ-1:0]  req_ready_q, req_ready_d;
  logic             busy_q,      busy_d;

  logic             any_valid_s;
  logic [IDW-1:0]   win_s;
  logic [WIDTH-1:0] win_data_s;
  logic             arb_s;

  // Pointer advance wraps by compare so non-power-of-2 NREQ works.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    logic [IDW-1:0] nxt;
    nxt = (idx == LAST_IDX) ? {IDW{1'b0}} : idx + IDW'(1);
    return nxt;
  endfunction

  // Round-robin search: first valid requester starting at rr_ptr.
  always_comb begin
    logic [IDW-1:0] cand;
    logic           hit;
    cand        = rr_ptr_q;
    hit         = 1'b0;
    win_s       = rr_ptr_q;
    any_valid_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      hit         = !any_valid_s && bus.req_valid[cand];
      win_s       = hit ? cand : win_s;
      any_valid_s = any_valid_s | hit;
      cand        = wrap_inc(cand);
    end
  end

  // Winner's word, selected with constant slices.
  always_comb begin
    win_data_s = {WIDTH{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      win_data_s = (win_s == IDW'(k)) ? bus.req_data[k*WIDTH +: WIDTH] : win_data_s;
    end
  end

  // Frame sequencing; arb_s marks the edges on which a new LOAD may start.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    ser_load_d  = 1'b0;
    ser_data_d  = ser_data_q;
    grant_id_d  = grant_id_q;
    req_ready_d = {NREQ{1'b0}};
    arb_s       = 1'b0;

    case (state_q)
      S_IDLE: begin
        arb_s = 1'b1;
      end
      S_LOAD: begin
        state_d   = S_SHIFT;
        bit_cnt_d = {CW{1'b0}};
      end
      S_SHIFT: begin
        if (bit_cnt_q == LAST_CNT) begin
`ifdef P2S_ARB_GAP_EN
          state_d = S_GAP;
`else
          state_d = S_IDLE;
          arb_s   = 1'b1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
`ifdef P2S_ARB_GAP_EN
      S_GAP: begin
        state_d = S_IDLE;
        arb_s   = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (arb_s && any_valid_s) begin
      state_d    = S_LOAD;
      ser_load_d = 1'b1;
      ser_data_d = win_data_s;
      grant_id_d = win_s;
      rr_ptr_d   = wrap_inc(win_s);
      for (int k = 0; k < NREQ; k++) begin
        req_ready_d[k] = (win_s == IDW'(k));
      end
    end else begin
      ser_load_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; rst abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= {CW{1'b0}};
      rr_ptr_q    <= {IDW{1'b0}};
      ser_load_q  <= 1'b0;
      ser_data_q  <= {WIDTH{1'b0}};
      grant_id_q  <= {IDW{1'b0}};
      req_ready_q <= {NREQ{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      ser_load_q  <= ser_load_d;
      ser_data_q  <= ser_data_d;
      grant_id_q  <= grant_id_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ser_load  = ser_load_q;
  assign bus.ser_data  = ser_data_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_p2s_rr_sched.sv
// Bench for p2s_rr_sched: per-requester word queues, a frame-age reference model,
// directed scenarios, random traffic with reset pulses, and a serializer tap.
module tb_p2s_rr_sched;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;
  localparam int DEPTH = 64;
`ifdef P2S_ARB_GAP_EN
  localparam int PERIOD = WIDTH + 1;
`else
  localparam int PERIOD = WIDTH;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  p2s_rr_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();
  p2s_rr_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [WIDTH-1:0] fifo [NREQ][DEPTH];
  int head [NREQ];
  int tail [NREQ];

  // Reference model: age of current frame (-1 when idle), pointer, held outputs.
  int               m_age = -1;
  int               m_ptr = 0;
  logic [IDW-1:0]   m_gid = '0;
  logic [WIDTH-1:0] m_data = '0;
  logic             m_load = 1'b0;
  logic [NREQ-1:0]  m_ready = '0;

  int gl [64];
  int gt [64];
  int gn = 0;

  logic [WIDTH-1:0] tap_sh = '0;
  int               tap_left = 0;
  logic [127:0]     sbits = '0;
  int               sn = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int qlen(input int k);
    return tail[k] - head[k];
  endfunction

  task automatic push(input int k, input logic [WIDTH-1:0] w);
    fifo[k][tail[k] % DEPTH] = w;
    tail[k]++;
  endtask

  task automatic flush();
    for (int k = 0; k < NREQ; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < NREQ; k++) begin
      bus.req_valid[k] = (qlen(k) > 0);
      bus.req_data[k*WIDTH +: WIDTH] = (qlen(k) > 0) ? fifo[k][head[k] % DEPTH] : '0;
    end
  endtask

  task automatic model_step();
    int  win;
    bit  found;
    m_load  = 1'b0;
    m_ready = '0;
    found   = 1'b0;
    win     = 0;
    if (rst) begin
      m_age  = -1;
      m_ptr  = 0;
      m_gid  = '0;
      m_data = '0;
    end else if (m_age >= 0 && m_age < PERIOD - 1) begin
      m_age++;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (!found && bus.req_valid[k]) begin
          found = 1'b1;
          win   = k;
        end
      end
      if (found) begin
        m_age        = 0;
        m_load       = 1'b1;
        m_ready[win] = 1'b1;
        m_gid        = IDW'(win);
        m_data       = fifo[win][head[win] % DEPTH];
        m_ptr        = (win + 1) % NREQ;
      end else begin
        m_age = -1;
      end
    end
  endtask

  task automatic cycle(input int pct, input logic [NREQ-1:0] mask);
    for (int k = 0; k < NREQ; k++) begin
      if (mask[k] && qlen(k) < 4 && $urandom_range(99) < pct)
        push(k, WIDTH'($urandom));
    end
    drive_inputs();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("ser_load",  32'(bus.ser_load),  32'(m_load));
    check("req_ready", 32'(bus.req_ready), 32'(m_ready));
    check("busy",      32'(bus.busy),      32'(m_age >= 0));
    check("grant_id",  32'(bus.grant_id),  32'(m_gid));
    check("ser_data",  32'(bus.ser_data),  32'(m_data));
    if (bus.ser_load && gn < 64) begin
      gl[gn] = int'(bus.grant_id);
      gt[gn] = cyc;
      gn++;
    end
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_ready[k] && qlen(k) > 0) head[k]++;
    end
    if (bus.ser_load) begin
      tap_sh   = bus.ser_data;
      tap_left = WIDTH;
    end
    if (tap_left > 0) begin
      sbits = {sbits[126:0], tap_sh[WIDTH-1]};
      tap_sh = tap_sh << 1;
      tap_left--;
      sn++;
    end
  endtask

  task automatic do_reset();
    flush();
    rst = 1'b1;
    cycle(0, '0);
    cycle(0, '0);
    rst = 1'b0;
    gn = 0;
    check("rst_load",  32'(bus.ser_load),  32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_gid",   32'(bus.grant_id),  32'd0);
    check("rst_data",  32'(bus.ser_data),  32'd0);
  endtask

  initial begin
    int busy_cnt;
    logic [127:0] pat;
    int exp2 [5];
    bus.req_valid = '0;
    bus.req_data  = '0;
    flush();

    // Single requester 2 with 4'hA from idle.
    do_reset();
    push(2, 4'hA);
    cycle(0, '0);
    check("t1_load",  32'(bus.ser_load),  32'd1);
    check("t1_data",  32'(bus.ser_data),  32'hA);
    check("t1_gid",   32'(bus.grant_id),  32'd2);
    check("t1_ready", 32'(bus.req_ready), 32'b0100);
    busy_cnt = int'(bus.busy);
    for (int c = 0; c < PERIOD + 2; c++) begin
      cycle(0, '0);
      busy_cnt += int'(bus.busy);
    end
    check("t1_busy_cycles", 32'(busy_cnt), 32'(PERIOD));

    // All four valid held high: strict rotation, one load per PERIOD.
    do_reset();
    for (int k = 0; k < NREQ; k++)
      for (int j = 0; j < 5; j++) push(k, WIDTH'($urandom));
    for (int c = 0; c < 5 * PERIOD + 1; c++) cycle(0, '0);
    exp2 = '{0, 1, 2, 3, 0};
    check("t2_nloads", 32'(gn >= 5), 32'd1);
    for (int i = 0; i < 5; i++) check("t2_grant", 32'(gl[i]), 32'(exp2[i]));
    for (int i = 0; i < 4; i++) check("t2_spacing", 32'(gt[i+1] - gt[i]), 32'(PERIOD));

    // After a grant to 1, only 0 and 3 pending: 3 then 0.
    do_reset();
    push(1, 4'h5);
    cycle(0, '0);
    push(0, 4'h6);
    push(3, 4'h7);
    for (int c = 0; c < 3 * PERIOD; c++) cycle(0, '0);
    check("t3_n", 32'(gn), 32'd3);
    check("t3_g0", 32'(gl[0]), 32'd1);
    check("t3_g1", 32'(gl[1]), 32'd3);
    check("t3_g2", 32'(gl[2]), 32'd0);

    // Reset during the second SHIFT cycle, then pointer restarts at 0.
    do_reset();
    push(2, 4'h7);
    push(3, 4'h9);
    cycle(0, '0);
    cycle(0, '0);
    cycle(0, '0);
    rst = 1'b1;
    cycle(0, '0);
    rst = 1'b0;
    check("t4_load",  32'(bus.ser_load),  32'd0);
    check("t4_busy",  32'(bus.busy),      32'd0);
    check("t4_gid",   32'(bus.grant_id),  32'd0);
    check("t4_data",  32'(bus.ser_data),  32'd0);
    check("t4_ready", 32'(bus.req_ready), 32'd0);
    push(0, 4'h1);
    cycle(0, '0);
    check("t4_regrant_gid",  32'(bus.grant_id), 32'd0);
    check("t4_regrant_data", 32'(bus.ser_data), 32'h1);
    for (int c = 0; c < 3 * PERIOD; c++) cycle(0, '0);

    // Random traffic with occasional reset pulses.
    for (int blk = 0; blk < 10; blk++) begin
      int pct;
      logic [NREQ-1:0] mask;
      pct  = $urandom_range(60, 5);
      mask = NREQ'($urandom);
      for (int c = 0; c < 200; c++) begin
        rst = ($urandom_range(99) == 0);
        cycle(pct, mask);
      end
      rst = 1'b0;
    end

    // Requester 0 streams a 128-bit pattern; serial tap must rebuild it.
    do_reset();
    pat = 128'hDEADBEEF_CAFEBABE_0123456789ABCDEF;
    for (int i = 0; i < 32; i++) push(0, pat[127 - 4*i -: 4]);
    sn = 0;
    tap_left = 0;
    sbits = '0;
    for (int c = 0; c < 40 * PERIOD && !(qlen(0) == 0 && m_age < 0); c++) cycle(0, '0);
    check("t6_bits", 32'(sn), 32'd128);
    check("t6_w3", sbits[127:96], pat[127:96]);
    check("t6_w2", sbits[95:64],  pat[95:64]);
    check("t6_w1", sbits[63:32],  pat[63:32]);
    check("t6_w0", sbits[31:0],   pat[31:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
